// File: rtl/cordic_rr_scheduler.sv
// ---------------------------------------------------------------------------
// cordic_rr_scheduler
//
// Round-robin front end that shares one sequential CORDIC sin/cos engine
// among NUM_REQ requesters. An angle is accepted from the granted requester
// and the engine is started with a start/busy handshake. The scheduler then
// waits for the engine's done pulse and returns sin/cos, tagged with the
// requester index, on a valid/ready response port. If the engine does not
// finish within TIMEOUT_CYC cycles, an error response with zero data is
// returned instead. Theta and the results pass through unchanged.
//
// Ports
//   i_clock, i_Reset      clock; synchronous active-high reset
//   i_Req_Valid[k]        requester k has an angle pending (held until taken)
//   i_Req_Theta           packed angles, requester k at [16k+15:16k]
//   o_Req_Ready           one-hot accept strobe (combinational, IDLE only)
//   o_Eng_Theta/Valid     angle and start request to the engine
//   i_Eng_Busy/Done       engine busy flag / one-cycle completion pulse
//   i_Eng_Sin/Cos         engine results, valid with i_Eng_Done
//   o_Rsp_Valid/Id/Sin/Cos/Err, i_Rsp_Ready   tagged response port
//   o_Busy                high whenever a request is being serviced
// ---------------------------------------------------------------------------
module cordic_rr_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 31
) (
    input  logic                    i_clock,
    input  logic                    i_Reset,
    input  logic [NUM_REQ-1:0]      i_Req_Valid,
    input  logic [16*NUM_REQ-1:0]   i_Req_Theta,
    output logic [NUM_REQ-1:0]      o_Req_Ready,
    output logic [15:0]             o_Eng_Theta,
    output logic                    o_Eng_Valid,
    input  logic                    i_Eng_Busy,
    input  logic                    i_Eng_Done,
    input  logic [15:0]             i_Eng_Sin,
    input  logic [15:0]             i_Eng_Cos,
    output logic                    o_Rsp_Valid,
    output logic [ID_W-1:0]         o_Rsp_Id,
    output logic [15:0]             o_Rsp_Sin,
    output logic [15:0]             o_Rsp_Cos,
    output logic                    o_Rsp_Err,
    input  logic                    i_Rsp_Ready,
    output logic                    o_Busy
);

    localparam int DATA_W = 16;
    // Timeout fires on the edge where the cycle count reaches TIMEOUT_CYC.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     last_grant;
    logic [7:0]          tmo_cnt;

    logic                grant_vld;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     cand;
    logic [DATA_W-1:0]   sel_theta;

    // Round-robin search starting at last_grant+1. Scanning from the far end
    // back towards the nearest candidate lets the nearest valid one win.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (i_Req_Valid[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        sel_theta = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                sel_theta = i_Req_Theta[DATA_W*k +: DATA_W];
            end
        end
    end

    // Reset wins over a simultaneous accept, so the strobe is withheld then.
    assign o_Req_Ready = (state == S_IDLE && grant_vld && !i_Reset)
                         ? (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge i_clock) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            last_grant  <= ID_W'(NUM_REQ - 1);
            tmo_cnt     <= '0;
            o_Eng_Valid <= 1'b0;
            o_Eng_Theta <= '0;
            o_Rsp_Valid <= 1'b0;
            o_Rsp_Id    <= '0;
            o_Rsp_Sin   <= '0;
            o_Rsp_Cos   <= '0;
            o_Rsp_Err   <= 1'b0;
            o_Busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        o_Eng_Theta <= sel_theta;
                        o_Rsp_Id    <= grant_id;
                        last_grant  <= grant_id;
                        tmo_cnt     <= '0;
                        o_Eng_Valid <= 1'b1;
                        o_Busy      <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (tmo_cnt == TMO_LAST) begin
                        o_Eng_Valid <= 1'b0;
                        o_Rsp_Valid <= 1'b1;
                        o_Rsp_Err   <= 1'b1;
                        o_Rsp_Sin   <= '0;
                        o_Rsp_Cos   <= '0;
                        state       <= S_RESP;
                    end else if (i_Eng_Busy) begin
                        // Drop start as soon as the engine has taken it so a
                        // returning-to-idle engine is never restarted.
                        o_Eng_Valid <= 1'b0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    // A done pulse on the timeout cycle still delivers data.
                    if (i_Eng_Done) begin
                        o_Rsp_Valid <= 1'b1;
                        o_Rsp_Err   <= 1'b0;
                        o_Rsp_Sin   <= i_Eng_Sin;
                        o_Rsp_Cos   <= i_Eng_Cos;
                        state       <= S_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        o_Rsp_Valid <= 1'b1;
                        o_Rsp_Err   <= 1'b1;
                        o_Rsp_Sin   <= '0;
                        o_Rsp_Cos   <= '0;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_Rsp_Ready) begin
                        o_Rsp_Valid <= 1'b0;
                        o_Busy      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
`timescale 1ns/1ps
module tb_cordic_rr_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int ID_W        = 2;
    localparam int TIMEOUT_CYC = 31;
    localparam int LAT_OK      = 15;   // accept edge to first visible response
    localparam int DONE_AT     = 13;   // engine count at which done is raised

    logic                  clk;
    logic                  rst;
    logic                  eng_rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_theta;
    logic [NUM_REQ-1:0]    req_ready;
    logic [15:0]           eng_theta;
    logic                  eng_valid;
    logic                  eng_busy;
    logic                  eng_done;
    logic [15:0]           eng_sin;
    logic [15:0]           eng_cos;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_sin;
    logic [15:0]           rsp_cos;
    logic                  rsp_err;
    logic                  rsp_ready;
    logic                  busy;

    bit                    no_done;
    bit                    chk_en;
    int                    n_checks;
    int                    n_fail;

    cordic_rr_scheduler #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clock     (clk),
        .i_Reset     (rst),
        .i_Req_Valid (req_valid),
        .i_Req_Theta (req_theta),
        .o_Req_Ready (req_ready),
        .o_Eng_Theta (eng_theta),
        .o_Eng_Valid (eng_valid),
        .i_Eng_Busy  (eng_busy),
        .i_Eng_Done  (eng_done),
        .i_Eng_Sin   (eng_sin),
        .i_Eng_Cos   (eng_cos),
        .o_Rsp_Valid (rsp_valid),
        .o_Rsp_Id    (rsp_id),
        .o_Rsp_Sin   (rsp_sin),
        .o_Rsp_Cos   (rsp_cos),
        .o_Rsp_Err   (rsp_err),
        .i_Rsp_Ready (rsp_ready),
        .o_Busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- engine model: sin = theta, cos = ~theta ----------------
    logic [15:0] eng_arg;
    int          eng_cnt;
    int          eng_starts;
    int          done_seen;

    always @(posedge clk) begin
        if (eng_rst) begin
            eng_busy   <= 1'b0;
            eng_done   <= 1'b0;
            eng_sin    <= '0;
            eng_cos    <= '0;
            eng_arg    <= '0;
            eng_cnt    <= 0;
            eng_starts <= 0;
            done_seen  <= 0;
        end else begin
            eng_done <= 1'b0;
            if (eng_done) done_seen <= done_seen + 1;
            if (!eng_busy) begin
                if (eng_valid) begin
                    eng_busy   <= 1'b1;
                    eng_cnt    <= 1;
                    eng_arg    <= eng_theta;
                    eng_starts <= eng_starts + 1;
                end
            end else begin
                eng_cnt <= eng_cnt + 1;
                if (eng_cnt == DONE_AT) begin
                    eng_busy <= 1'b0;
                    if (!no_done) begin
                        eng_done <= 1'b1;
                        eng_sin  <= eng_arg;
                        eng_cos  <= ~eng_arg;
                    end
                end
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (v[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
        end
        return -1;
    endfunction

    int              cyc;
    bit              outstanding;
    bit              issuing;
    int              last_g;
    int              acc_cyc;
    int              exp_lat;
    int              rsp_count;
    logic [ID_W-1:0] exp_id;
    logic [15:0]     exp_theta;
    logic [15:0]     exp_sin;
    logic [15:0]     exp_cos;
    logic            exp_err;

    always @(posedge clk) begin
        int g;
        cyc = cyc + 1;
        if (rst) begin
            outstanding = 1'b0;
            issuing     = 1'b0;
            last_g      = NUM_REQ - 1;
        end else if (outstanding) begin
            if (issuing && (eng_busy || (cyc - acc_cyc) >= TIMEOUT_CYC)) issuing = 1'b0;
            if ((cyc - 1 - acc_cyc) >= exp_lat && rsp_ready) begin
                outstanding = 1'b0;
                rsp_count   = rsp_count + 1;
            end
        end else if (|req_valid) begin
            g           = rr_pick(last_g, req_valid);
            outstanding = 1'b1;
            issuing     = 1'b1;
            last_g      = g;
            acc_cyc     = cyc;
            exp_id      = g[ID_W-1:0];
            exp_theta   = req_theta[16*g +: 16];
            exp_lat     = no_done ? TIMEOUT_CYC : LAT_OK;
            exp_err     = no_done;
            exp_sin     = no_done ? 16'h0000 : exp_theta;
            exp_cos     = no_done ? 16'h0000 : ~exp_theta;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks = n_checks + 1;
        if (act !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic [NUM_REQ-1:0] exp_ready;
    bit                 exp_rv;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_ready = '0;
            if (!outstanding && !rst && |req_valid)
                exp_ready = NUM_REQ'(1) << rr_pick(last_g, req_valid);
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("busy", 32'(busy), 32'(outstanding));
            check("eng_valid", 32'(eng_valid), 32'(issuing));
            if (issuing) check("eng_theta", 32'(eng_theta), 32'(exp_theta));
            exp_rv = outstanding && ((cyc - acc_cyc) >= exp_lat);
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv) begin
                check("rsp_id", 32'(rsp_id), 32'(exp_id));
                check("rsp_sin", 32'(rsp_sin), 32'(exp_sin));
                check("rsp_cos", 32'(rsp_cos), 32'(exp_cos));
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int glog[$];

    task automatic run_grants(input int n, input bit drop);
        int guard = 0;
        int gi;
        glog.delete();
        while (glog.size() < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            gi = -1;
            for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) gi = k;
            if (gi >= 0) glog.push_back(gi);
            @(posedge clk);
            #1;
            if (gi >= 0 && drop) req_valid[gi] = 1'b0;
            if (glog.size() >= n) req_valid = '0;
        end
        check("grant_count", 32'(glog.size()), 32'(n));
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid) break;
        end
        check("rsp_arrives", 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (busy && g < 500);
        check("idle_reached", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        int starts0;
        logic [15:0] s_sin, s_cos;
        logic [ID_W-1:0] s_id;

        rst = 1'b1; eng_rst = 1'b1; req_valid = '0; req_theta = '0;
        rsp_ready = 1'b1; no_done = 1'b0; chk_en = 1'b0;
        n_checks = 0; n_fail = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; eng_rst = 1'b0; chk_en = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_eng_valid", 32'(eng_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;

        // fairness: all four continuously valid
        for (int k = 0; k < NUM_REQ; k++) req_theta[16*k +: 16] = 16'((k + 1) * 16'h0100);
        base = rsp_count;
        req_valid = 4'b1111;
        run_grants(5, 1'b0);
        wait_idle();
        check("rr_order", {glog[0][7:0], glog[1][7:0], glog[2][7:0], glog[3][7:0]}, 32'h00010203);
        check("rr_fifth", 32'(glog[4]), 32'd0);
        check("rr_rsp_count", 32'(rsp_count - base), 32'd5);

        // single request from requester 2
        starts0 = eng_starts;
        req_theta[2*16 +: 16] = 16'h1234;
        req_valid = 4'b0100;
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_rsp(lat);
        check("single_latency", 32'(lat), 32'd15);
        check("single_id", 32'(rsp_id), 32'd2);
        check("single_sin", 32'(rsp_sin), 32'h1234);
        check("single_cos", 32'(rsp_cos), 32'hEDCB);
        check("single_err", 32'(rsp_err), 32'd0);
        check("single_issues", 32'(eng_starts - starts0), 32'd1);
        wait_idle();

        // back-pressure
        rsp_ready = 1'b0;
        req_theta[3*16 +: 16] = 16'hBEEF;
        req_valid = 4'b1000;
        run_grants(1, 1'b1);
        wait_rsp(lat);
        s_id = rsp_id; s_sin = rsp_sin; s_cos = rsp_cos;
        check("bp_id", 32'(s_id), 32'd3);
        check("bp_sin", 32'(s_sin), 32'hBEEF);
        check("bp_cos", 32'(s_cos), 32'h4110);
        @(posedge clk);
        #1;
        req_theta[0 +: 16] = 16'hA5A5;
        req_valid = 4'b0001;
        base = rsp_count;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_sin", 32'(rsp_sin), 32'(s_sin));
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_one_rsp", 32'(rsp_count - base), 32'd1);
        check("bp_valid_drop", 32'(rsp_valid), 32'd0);
        run_grants(1, 1'b1);
        check("bp_next_grant", 32'(glog[0]), 32'd0);
        wait_idle();

        // timeout: engine never signals done
        no_done = 1'b1;
        req_theta[1*16 +: 16] = 16'h7777;
        req_valid = 4'b0010;
        run_grants(1, 1'b1);
        wait_rsp(lat);
        check("tmo_latency", 32'(lat), 32'd31);
        check("tmo_err", 32'(rsp_err), 32'd1);
        check("tmo_sin", 32'(rsp_sin), 32'd0);
        check("tmo_cos", 32'(rsp_cos), 32'd0);
        check("tmo_eng_valid", 32'(eng_valid), 32'd0);
        wait_idle();
        no_done = 1'b0;
        req_theta[1*16 +: 16] = 16'h2222;
        req_valid = 4'b0010;
        run_grants(1, 1'b1);
        wait_rsp(lat);
        check("post_tmo_latency", 32'(lat), 32'd15);
        check("post_tmo_err", 32'(rsp_err), 32'd0);
        check("post_tmo_sin", 32'(rsp_sin), 32'h2222);
        wait_idle();

        // reset in the middle of an engine run
        req_theta[2*16 +: 16] = 16'h3333;
        req_valid = 4'b0100;
        run_grants(1, 1'b1);
        base = done_seen;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_eng_valid", 32'(eng_valid), 32'd0);
        check("mid_rst_engine_busy", 32'(eng_busy), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("stale_done_seen", 32'(done_seen - base), 32'd1);
        base = rsp_count;
        req_theta[0 +: 16] = 16'h0F0F;
        req_valid = 4'b0101;
        run_grants(2, 1'b1);
        check("post_rst_first", 32'(glog[0]), 32'd0);
        check("post_rst_second", 32'(glog[1]), 32'd2);
        wait_idle();
        check("post_rst_rsp_count", 32'(rsp_count - base), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
